// File: rtl/cordic_selftest_ctrl_if.sv
// Bus between the self-test controller and the CORDIC core plus its stimulus/golden ROMs.
interface cordic_selftest_ctrl_if #(
    parameter int unsigned OUT_BITS  = 16,
    parameter int unsigned ADDR_BITS = 4
);
    logic                        din_valid;
    logic        [ADDR_BITS-1:0] stim_addr;
    logic                        rfd;
    logic                        dout_valid;
    logic signed [OUT_BITS-1:0]  dut_x;
    logic signed [OUT_BITS-1:0]  dut_y;
    logic signed [OUT_BITS-1:0]  dut_a;
    logic        [ADDR_BITS-1:0] gold_addr;
    logic signed [OUT_BITS-1:0]  gold1;
    logic signed [OUT_BITS-1:0]  gold2;

    // Controller side
    modport master (
        output din_valid, stim_addr, gold_addr,
        input  rfd, dout_valid, dut_x, dut_y, dut_a, gold1, gold2
    );

    // CORDIC core / ROM side
    modport slave (
        input  din_valid, stim_addr, gold_addr,
        output rfd, dout_valid, dut_x, dut_y, dut_a, gold1, gold2
    );
endinterface

// File: rtl/cordic_selftest_ctrl.sv
// On-chip self-test sequencer/checker for CORECORDIC: paces stimulus issue, compares each
// result against golden words within a tolerance and reports pass/fail, timeout and overrun.
module cordic_selftest_ctrl #(
    parameter int unsigned OUT_BITS  = 16,
    parameter int unsigned NUM_VECT  = 16,
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned TOL       = 0,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned ERR_BITS  = 8
) (
    input  logic                   clk,
    input  logic                   nGrst,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [2:0]             i_pace_mode,
    input  logic                   i_cmp_mode,
    cordic_selftest_ctrl_if.master m_bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_fail,
    output logic [ERR_BITS-1:0]    o_err_count,
    output logic [ADDR_BITS-1:0]   o_first_err,
    output logic                   o_timeout_flag,
    output logic                   o_overrun_flag
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [ADDR_BITS:0]       LP_NUM      = (ADDR_BITS+1)'(NUM_VECT);
    localparam logic [ADDR_BITS:0]       LP_LAST     = (ADDR_BITS+1)'(NUM_VECT - 1);
    localparam logic [TW-1:0]            LP_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic signed [OUT_BITS:0] LP_TOL      = (OUT_BITS+1)'(TOL);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StCheck, StDone} state_e;

    state_e                r_state, w_state_nxt;
    logic [ADDR_BITS:0]    r_issue;   // stimuli issued this run
    logic [ADDR_BITS:0]    r_rcv;     // results accepted this run
    logic [2:0]            r_phase;
    logic [2:0]            r_pace;
    logic                  r_cmp;
    logic [TW-1:0]         r_tmo;
    logic [ERR_BITS-1:0]   r_err_count;
    logic [ADDR_BITS-1:0]  r_first_err;
    logic                  r_fail, r_timeout, r_overrun;

    logic                  w_pace_on, w_din_valid, w_run_drain, w_start, w_all_rcv;
    logic                  w_accept, w_overrun, w_tmo_hit, w_mismatch;
    logic signed [OUT_BITS-1:0] w_field2;
    logic signed [OUT_BITS:0]   w_diff1, w_diff2;

    assign w_run_drain = (r_state == StRun) || (r_state == StDrain);
    assign w_start     = i_start && ((r_state == StIdle) || (r_state == StDone));
    assign w_all_rcv   = (r_rcv == LP_NUM);
    assign w_accept    = m_bus.dout_valid && w_run_drain && !w_all_rcv;
    // Results beyond NUM_VECT are flagged, never compared; a start in DONE takes priority.
    assign w_overrun   = m_bus.dout_valid && !w_start && (r_state != StIdle) && w_all_rcv;
    assign w_tmo_hit   = w_run_drain && !w_accept && !w_all_rcv && (r_tmo == LP_TMO_LAST);

    // Pacing gate from the latched mode and free-running phase counter
    always_comb begin
        w_pace_on = 1'b1;
        case (r_pace)
            3'd1:    w_pace_on = ~r_phase[0];
            3'd2:    w_pace_on = ~r_phase[1];
            3'd3:    w_pace_on = ~r_phase[2];
            3'd4:    w_pace_on = m_bus.rfd;
            default: w_pace_on = 1'b1;
        endcase
    end

    // Tolerance compare of both fields, widened one bit so the difference cannot overflow
    always_comb begin
        w_field2   = r_cmp ? m_bus.dut_a : m_bus.dut_y;
        w_diff1    = {m_bus.dut_x[OUT_BITS-1], m_bus.dut_x} - {m_bus.gold1[OUT_BITS-1], m_bus.gold1};
        w_diff2    = {w_field2[OUT_BITS-1], w_field2} - {m_bus.gold2[OUT_BITS-1], m_bus.gold2};
        w_mismatch = !((w_diff1 >= -LP_TOL) && (w_diff1 <= LP_TOL) &&
                       (w_diff2 >= -LP_TOL) && (w_diff2 <= LP_TOL));
    end

    // State register
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst)     r_state <= StIdle;
        else if (i_rst) r_state <= StIdle;
        else            r_state <= w_state_nxt;
    end

    // Next-state and stimulus issue; a timeout suppresses din_valid in the same clk
    always_comb begin
        w_state_nxt = r_state;
        w_din_valid = 1'b0;
        unique case (r_state)
            StIdle:  if (w_start) w_state_nxt = StRun;
            StRun: begin
                w_din_valid = w_pace_on && !w_tmo_hit;
                if (w_tmo_hit)                              w_state_nxt = StDone;
                else if (w_din_valid && (r_issue == LP_LAST)) w_state_nxt = StDrain;
            end
            StDrain: begin
                if (w_all_rcv)      w_state_nxt = StCheck;
                else if (w_tmo_hit) w_state_nxt = StDone;
            end
            StCheck: w_state_nxt = StDone;
            StDone:  if (w_start) w_state_nxt = StRun;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Run counters, registered compare results and status flags
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_issue <= '0; r_rcv <= '0; r_phase <= '0; r_pace <= '0; r_cmp <= 1'b0;
            r_tmo <= '0; r_err_count <= '0; r_first_err <= '0;
            r_fail <= 1'b0; r_timeout <= 1'b0; r_overrun <= 1'b0;
        end else if (i_rst) begin
            r_issue <= '0; r_rcv <= '0; r_phase <= '0; r_pace <= '0; r_cmp <= 1'b0;
            r_tmo <= '0; r_err_count <= '0; r_first_err <= '0;
            r_fail <= 1'b0; r_timeout <= 1'b0; r_overrun <= 1'b0;
        end else if (w_start) begin
            r_issue <= '0; r_rcv <= '0; r_phase <= '0; r_pace <= i_pace_mode; r_cmp <= i_cmp_mode;
            r_tmo <= '0; r_err_count <= '0; r_first_err <= '0;
            r_fail <= 1'b0; r_timeout <= 1'b0; r_overrun <= 1'b0;
        end else begin
            if (w_din_valid)        r_issue <= r_issue + 1'b1;
            if (r_state == StRun)   r_phase <= r_phase + 3'd1;
            if (w_accept) begin
                r_rcv <= r_rcv + 1'b1;
                r_tmo <= '0;
                if (w_mismatch) begin
                    r_fail <= 1'b1;
                    if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                    // err_count saturates above zero, so zero means no mismatch yet
                    if (r_err_count == '0) r_first_err <= r_rcv[ADDR_BITS-1:0];
                end
            end else if (w_run_drain) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_tmo_hit) begin
                r_timeout <= 1'b1;
                r_fail    <= 1'b1;
            end
            if (w_overrun) begin
                r_overrun <= 1'b1;
                r_fail    <= 1'b1;
            end
        end
    end

    assign m_bus.din_valid = w_din_valid;
    assign m_bus.stim_addr = r_issue[ADDR_BITS-1:0];
    assign m_bus.gold_addr = r_rcv[ADDR_BITS-1:0];
    assign o_busy          = (r_state == StRun) || (r_state == StDrain) || (r_state == StCheck);
    assign o_done          = (r_state == StDone);
    assign o_fail          = r_fail;
    assign o_err_count     = r_err_count;
    assign o_first_err     = r_first_err;
    assign o_timeout_flag  = r_timeout;
    assign o_overrun_flag  = r_overrun;

endmodule

// File: tb/tb_cordic_selftest_ctrl.sv
// Self-checking bench for cordic_selftest_ctrl: a behavioural CORDIC stand-in with fixed
// latency and golden ROMs, scoreboards for issue order/timing and result order.
module tb_cordic_selftest_ctrl;
    localparam int OB = 16;
    localparam int NV = 16;
    localparam int AB = 4;
    localparam int TOLP = 1;
    localparam int TMO = 64;
    localparam int EB = 8;

    typedef struct {int idx; int cyc;} ent_t;

    logic clk = 1'b0;
    logic nGrst = 1'b0;
    logic i_rst = 1'b0;
    logic i_start = 1'b0;
    logic [2:0] i_pace_mode = 3'd0;
    logic i_cmp_mode = 1'b0;
    logic o_busy, o_done, o_fail, o_timeout_flag, o_overrun_flag;
    logic [EB-1:0] o_err_count;
    logic [AB-1:0] o_first_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    ent_t exp_q[$];
    ent_t pend[$];
    int lat, res_limit, n_res, n_pushed, s_cyc, last_dv, err_rise, pace_cur;
    bit run_active = 1'b0;
    bit extra_pending = 1'b0;
    bit dv_force = 1'b0;
    int ex[NV];
    int ey[NV];
    int dv_cyc[NV];

    cordic_selftest_ctrl_if #(.OUT_BITS(OB), .ADDR_BITS(AB)) bus ();

    cordic_selftest_ctrl #(
        .OUT_BITS(OB), .NUM_VECT(NV), .ADDR_BITS(AB), .TOL(TOLP), .TIMEOUT(TMO), .ERR_BITS(EB)
    ) dut (
        .clk(clk), .nGrst(nGrst), .i_rst(i_rst), .i_start(i_start),
        .i_pace_mode(i_pace_mode), .i_cmp_mode(i_cmp_mode), .m_bus(bus),
        .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_err_count(o_err_count),
        .o_first_err(o_first_err), .o_timeout_flag(o_timeout_flag),
        .o_overrun_flag(o_overrun_flag)
    );

    always #5 clk = ~clk;

    // Golden ROM contents
    function automatic logic signed [OB-1:0] g1f(input int i);
        return OB'(i * 1000 - 7000);
    endfunction
    function automatic logic signed [OB-1:0] g2f(input int i);
        return OB'(12000 - i * 1537);
    endfunction
    assign bus.gold1 = g1f(int'(bus.gold_addr));
    assign bus.gold2 = g2f(int'(bus.gold_addr));

    function automatic int pace_off(input int pace, input int k);
        case (pace)
            1: return 2 * k;
            2: return (k / 2) * 4 + k % 2;
            3: return (k / 4) * 8 + k % 4;
            default: return k;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive rfd and results for the new cycle, then score stimulus issue
    task automatic tick();
        ent_t e;
        ent_t p;
        @(posedge clk); #1; cyc++;
        i_start = 1'b0;
        bus.rfd = (cyc % 19 == 0);
        if (bus.rfd && run_active && pace_cur == 4 && n_pushed < NV) begin
            e.idx = n_pushed; e.cyc = cyc; exp_q.push_back(e); n_pushed++;
        end
        bus.dout_valid = 1'b0;
        if (dv_force) begin
            bus.dout_valid = 1'b1; dv_force = 1'b0;
        end else if (pend.size() > 0 && pend[0].cyc <= cyc && n_res < res_limit) begin
            e = pend.pop_front();
            chk("gold_addr", 32'(bus.gold_addr), 32'(e.idx));
            bus.dut_x = OB'(int'(g1f(e.idx)) + ex[e.idx]);
            if (i_cmp_mode) begin
                bus.dut_a = OB'(int'(g2f(e.idx)) + ey[e.idx]);
                bus.dut_y = OB'(int'(g2f(e.idx)) - 555);
            end else begin
                bus.dut_y = OB'(int'(g2f(e.idx)) + ey[e.idx]);
                bus.dut_a = OB'(int'(g2f(e.idx)) + 777);
            end
            dv_cyc[e.idx] = cyc; last_dv = cyc; n_res++;
            bus.dout_valid = 1'b1;
        end else if (extra_pending && n_res == NV && cyc > last_dv) begin
            bus.dout_valid = 1'b1; bus.dut_x = 16'sh7fff; extra_pending = 1'b0;
        end
        #1;
        if (bus.din_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'(bus.din_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stim_addr", 32'(bus.stim_addr), 32'(e.idx));
                chk("issue_cyc", 32'(cyc), 32'(e.cyc));
                p.idx = e.idx; p.cyc = cyc + lat;
                pend.push_back(p);
            end
        end
        if (run_active && err_rise < 0 && o_err_count != '0) err_rise = cyc;
    endtask

    task automatic clear_err();
        for (int i = 0; i < NV; i++) begin ex[i] = 0; ey[i] = 0; dv_cyc[i] = 0; end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_fail"}, 32'(o_fail), 32'd0);
        chk({tag, "_err"}, 32'(o_err_count), 32'd0);
        chk({tag, "_first"}, 32'(o_first_err), 32'd0);
        chk({tag, "_tmo"}, 32'(o_timeout_flag), 32'd0);
        chk({tag, "_ovr"}, 32'(o_overrun_flag), 32'd0);
        chk({tag, "_dinv"}, 32'(bus.din_valid), 32'd0);
        chk({tag, "_stim"}, 32'(bus.stim_addr), 32'd0);
        chk({tag, "_gaddr"}, 32'(bus.gold_addr), 32'd0);
    endtask

    // Pulse start this cycle; paced modes have a fixed issue schedule known up front
    task automatic begin_run(input int pace, input int cmpm, input int latv, input int lim,
                             input bit extra);
        ent_t e;
        pend.delete(); exp_q.delete();
        pace_cur = pace; lat = latv; res_limit = lim; extra_pending = extra;
        n_res = 0; n_pushed = 0; last_dv = 0; err_rise = -1;
        i_pace_mode = 3'(pace); i_cmp_mode = cmpm[0]; i_start = 1'b1;
        s_cyc = cyc; run_active = 1'b1;
        if (pace != 4) begin
            for (int k = 0; k < NV; k++) begin
                e.idx = k; e.cyc = s_cyc + 1 + pace_off(pace, k); exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_test(input string name, input int pace, input int cmpm, input int lim,
                            input bit extra, input int e_fail, input int e_err,
                            input int e_first, input int e_tmo, input int e_ovr);
        bit got_done = 1'b0;
        int dcyc = 0;
        begin_run(pace, cmpm, 20, lim, extra);
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (o_done) begin got_done = 1'b1; dcyc = cyc; break; end
        end
        run_active = 1'b0;
        chk({name, "_done"}, 32'(got_done), 32'd1);
        chk({name, "_issues_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_busy"}, 32'(o_busy), 32'd0);
        chk({name, "_fail"}, 32'(o_fail), 32'(e_fail));
        chk({name, "_err"}, 32'(o_err_count), 32'(e_err));
        chk({name, "_first"}, 32'(o_first_err), 32'(e_first));
        chk({name, "_tmo"}, 32'(o_timeout_flag), 32'(e_tmo));
        chk({name, "_ovr"}, 32'(o_overrun_flag), 32'(e_ovr));
        chk({name, "_done_cyc"}, 32'(dcyc), 32'(e_tmo != 0 ? last_dv + TMO + 1 : last_dv + 3));
        tick();
        chk({name, "_done_held"}, 32'(o_done), 32'd1);
    endtask

    initial begin
        bus.rfd = 1'b0; bus.dout_valid = 1'b0;
        bus.dut_x = '0; bus.dut_y = '0; bus.dut_a = '0;
        lat = 20; res_limit = NV; n_res = 0; n_pushed = 0; pace_cur = 0;
        s_cyc = 0; last_dv = 0; err_rise = -1;
        clear_err();
        repeat (3) @(posedge clk);
        #1;
        all_zero("async_rst");
        nGrst = 1'b1;
        // dout_valid while idle must not advance or flag anything
        dv_force = 1'b1;
        tick(); tick();
        all_zero("idle_dv");

        run_test("t1_mode0", 0, 0, NV, 1'b0, 0, 0, 0, 0, 0);
        run_test("t2_mode1", 1, 0, NV, 1'b0, 0, 0, 0, 0, 0);
        run_test("t2_mode2", 2, 0, NV, 1'b0, 0, 0, 0, 0, 0);
        run_test("t2_mode3", 3, 0, NV, 1'b0, 0, 0, 0, 0, 0);
        run_test("mode6_as0", 6, 0, NV, 1'b0, 0, 0, 0, 0, 0);
        run_test("t3_mode4", 4, 0, NV, 1'b0, 0, 0, 0, 0, 0);

        clear_err();
        ex[5] = 1; ey[9] = -2;
        run_test("t4_tol", 1, 0, NV, 1'b0, 1, 1, 9, 0, 0);
        chk("t4_err_latency", 32'(err_rise), 32'(dv_cyc[9] + 1));

        clear_err();
        ey[3] = 2; ex[12] = -2; ey[8] = -1;
        run_test("vect_cmp", 0, 1, NV, 1'b0, 1, 2, 3, 0, 0);

        clear_err();
        run_test("t5_timeout", 2, 0, NV - 1, 1'b0, 1, 0, 0, 1, 0);
        run_test("t6_overrun", 0, 0, NV, 1'b1, 1, 0, 0, 0, 1);

        // Synchronous reset in the middle of a run
        begin_run(1, 0, 20, NV, 1'b0);
        repeat (8) tick();
        chk("midrun_busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0; run_active = 1'b0;
        exp_q.delete(); pend.delete();
        all_zero("sync_rst");
        tick();
        chk("sync_rst_idle", 32'(o_busy), 32'd0);

        run_test("after_rst", 0, 0, NV, 1'b0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
